// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, samples each bit at its centre and
// reports good bytes with a one-cycle strobe and framing errors with another.
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       received,
   output logic [7:0] rx_byte,
   output logic       is_receiving,
   output logic       recv_error,
   output logic [2:0] recv_state
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] ARM_LAST  = CNT_W'(CLKS_PER_BIT - 2);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      CHECK_START = 3'd1,
      READ_BITS   = 3'd2,
      CHECK_STOP  = 3'd3,
      RECEIVED    = 3'd4,
      ERROR       = 3'd5,
      WAIT_IDLE   = 3'd6
   } state_t;

   state_t           state;
   logic             rx_meta;
   logic             rx_s;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;
   logic             armed;

   assign recv_state = state;

   // Two-flop synchroniser, idles high so reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= WAIT_IDLE;
         cnt          <= '0;
         bit_idx      <= '0;
         shift        <= '0;
         armed        <= 1'b0;
         received     <= 1'b0;
         recv_error   <= 1'b0;
         rx_byte      <= '0;
         is_receiving <= 1'b0;
      end else begin
         received   <= 1'b0;
         recv_error <= 1'b0;
         unique case (state)
            // Leave only after a full bit time of continuous high line;
            // 'armed' makes the first high cycle after entry count as one.
            WAIT_IDLE: begin
               if (!rx_s) begin
                  cnt   <= BIT_LAST;
                  armed <= 1'b1;
               end else if (!armed) begin
                  cnt   <= ARM_LAST;
                  armed <= 1'b1;
               end else if (cnt == '0) begin
                  state <= IDLE;
                  armed <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            IDLE: begin
               if (!rx_s) begin
                  state        <= CHECK_START;
                  cnt          <= HALF_LAST;
                  is_receiving <= 1'b1;
               end
            end
            CHECK_START: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_ONE;
               end else if (!rx_s) begin
                  state   <= READ_BITS;
                  cnt     <= BIT_LAST;
                  bit_idx <= '0;
               end else begin
                  state        <= IDLE;
                  is_receiving <= 1'b0;
               end
            end
            READ_BITS: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_ONE;
               end else begin
                  shift   <= {rx_s, shift[7:1]};
                  cnt     <= BIT_LAST;
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state <= CHECK_STOP;
               end
            end
            CHECK_STOP: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_ONE;
               end else begin
                  is_receiving <= 1'b0;
                  state        <= rx_s ? RECEIVED : ERROR;
               end
            end
            RECEIVED: begin
               rx_byte  <= shift;
               received <= 1'b1;
               state    <= IDLE;
            end
            ERROR: begin
               recv_error <= 1'b1;
               state      <= WAIT_IDLE;
            end
            default: begin
               state        <= WAIT_IDLE;
               armed        <= 1'b0;
               is_receiving <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised self-checking bench for uart_rx against a frame-level model:
// good-stop frames deliver their byte, bad-stop frames give one error.
module tb_uart_rx;

   localparam int unsigned CPB = 16;
   localparam int LAT_NOM  = (19 * CPB) / 2 + 4;
   localparam int RXHI_NOM = (19 * CPB) / 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       received;
   logic [7:0] rx_byte;
   logic       is_receiving;
   logic       recv_error;
   logic [2:0] recv_state;

   int          n_checks = 0;
   int          n_fail   = 0;
   int unsigned cyc      = 0;
   int unsigned t_start  = 0;
   int unsigned last_rcv_cyc = 0;
   int          n_rcv = 0;
   int          n_err = 0;
   int          n_rxhi = 0;
   int          n_cs = 0;
   bit          both_high = 1'b0;
   logic [7:0]  got_q[$];
   logic [7:0]  exp_q[$];

   always #5 clk = ~clk;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk),
      .rst(rst),
      .rx(rx),
      .received(received),
      .rx_byte(rx_byte),
      .is_receiving(is_receiving),
      .recv_error(recv_error),
      .recv_state(recv_state)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (rst) begin
         if (received) begin
            n_rcv++;
            got_q.push_back(rx_byte);
            last_rcv_cyc = cyc;
         end
         if (recv_error) n_err++;
         if (received && recv_error) both_high = 1'b1;
         if (is_receiving) n_rxhi++;
         if (recv_state == 3'd1) n_cs++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] got_at(input int i);
      if (i >= 0 && i < got_q.size()) return got_q[i];
      return 8'hxx;
   endfunction

   // Entered and left at posedge+1.
   task automatic drive(input logic v, input int n);
      rx = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      t_start = cyc;
      drive(1'b0, CPB);
      for (int i = 0; i < 8; i++) drive(b[i], CPB);
      drive(stop, CPB);
   endtask

   initial begin
      int r0, e0, h0, c0, n, lat, exp_err;
      logic [7:0] b;
      logic       bad;

      rx  = 1'b1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_received", 32'(received), 0);
      check("rst_error", 32'(recv_error), 0);
      check("rst_byte", 32'(rx_byte), 0);
      check("rst_busy", 32'(is_receiving), 0);
      check("rst_state", 32'(recv_state), 6);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_state", 32'(recv_state), 6);
      repeat (20) @(posedge clk); #1;
      check("idle_state", 32'(recv_state), 0);

      // Single frame with latency and busy-window checks.
      r0 = n_rcv; e0 = n_err; h0 = n_rxhi;
      send_frame(8'hAA, 1'b1);
      drive(1'b1, 20);
      lat = int'(last_rcv_cyc - t_start);
      check("aa_count", 32'(n_rcv - r0), 1);
      check("aa_byte", 32'(got_at(r0)), 32'h0AA);
      check("aa_err", 32'(n_err - e0), 0);
      check("aa_latency", (lat >= LAT_NOM - 1 && lat <= LAT_NOM + 1) ? 32'(LAT_NOM) : 32'(lat),
            32'(LAT_NOM));
      n = n_rxhi - h0;
      check("aa_busy_len", (n >= RXHI_NOM - 1 && n <= RXHI_NOM + 1) ? 32'(RXHI_NOM) : 32'(n),
            32'(RXHI_NOM));

      // Back-to-back frames.
      r0 = n_rcv; e0 = n_err;
      send_frame(8'h55, 1'b1);
      send_frame(8'h00, 1'b1);
      drive(1'b1, 20);
      check("b2b_count", 32'(n_rcv - r0), 2);
      check("b2b_first", 32'(got_at(r0)), 32'h55);
      check("b2b_second", 32'(got_at(r0 + 1)), 32'h00);
      check("b2b_err", 32'(n_err - e0), 0);

      // Short glitch is rejected silently.
      r0 = n_rcv; e0 = n_err; c0 = n_cs;
      drive(1'b0, 4);
      drive(1'b1, 30);
      check("glitch_saw_start", 32'(n_cs > c0), 1);
      check("glitch_state", 32'(recv_state), 0);
      check("glitch_rcv", 32'(n_rcv - r0), 0);
      check("glitch_err", 32'(n_err - e0), 0);
      check("glitch_byte", 32'(rx_byte), 32'h00);

      // Bad stop bit, line held low, then recovery timing.
      r0 = n_rcv; e0 = n_err;
      send_frame(8'h3C, 1'b0);
      drive(1'b0, 40);
      check("ferr_state_low", 32'(recv_state), 6);
      rx = 1'b1;
      n = 0;
      while (n < 100) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (recv_state == 3'd0) break;
      end
      check("ferr_recover", (n >= int'(CPB) - 2 && n <= int'(CPB) + 2) ? 32'(CPB) : 32'(n),
            32'(CPB));
      @(posedge clk); #1;
      drive(1'b1, 10);
      check("ferr_err", 32'(n_err - e0), 1);
      check("ferr_rcv", 32'(n_rcv - r0), 0);
      check("ferr_byte", 32'(rx_byte), 32'h00);

      // Reset in the middle of a frame discards it.
      send_frame(8'h7E, 1'b1);
      drive(1'b1, 20);
      check("pre_rst_byte", 32'(rx_byte), 32'h7E);
      r0 = n_rcv; e0 = n_err;
      fork
         send_frame(8'hF0, 1'b1);
         begin
            repeat (CPB * 5 + 8) @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            check("mid_rst_received", 32'(received), 0);
            check("mid_rst_error", 32'(recv_error), 0);
            check("mid_rst_busy", 32'(is_receiving), 0);
            check("mid_rst_byte", 32'(rx_byte), 0);
            check("mid_rst_state", 32'(recv_state), 6);
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b1;
         end
      join
      drive(1'b1, 20);
      check("mid_rst_rcv", 32'(n_rcv - r0), 0);
      check("mid_rst_err", 32'(n_err - e0), 0);
      check("mid_rst_byte_after", 32'(rx_byte), 0);
      r0 = n_rcv;
      send_frame(8'hA5, 1'b1);
      drive(1'b1, 20);
      check("a5_count", 32'(n_rcv - r0), 1);
      check("a5_byte", 32'(rx_byte), 32'hA5);

      // Break condition.
      r0 = n_rcv; e0 = n_err;
      drive(1'b0, 200);
      check("break_err", 32'(n_err - e0), 1);
      check("break_rcv", 32'(n_rcv - r0), 0);
      check("break_state", 32'(recv_state), 6);
      drive(1'b1, 40);
      check("break_recover", 32'(recv_state), 0);

      // Random frames against the frame-level model.
      r0 = n_rcv; e0 = n_err; exp_err = 0;
      exp_q.delete();
      for (int k = 0; k < 40; k++) begin
         b   = 8'($urandom);
         bad = ($urandom_range(5) == 0);
         send_frame(b, !bad);
         if (bad) begin
            exp_err++;
            drive(1'b1, int'($urandom_range(32, 24)));
         end else begin
            exp_q.push_back(b);
            drive(1'b1, int'($urandom_range(20, 0)));
         end
      end
      drive(1'b1, 30);
      check("rand_count", 32'(n_rcv - r0), 32'(exp_q.size()));
      check("rand_err", 32'(n_err - e0), 32'(exp_err));
      for (int i = 0; i < exp_q.size(); i++)
         check("rand_byte", 32'(got_at(r0 + i)), 32'(exp_q[i]));
      if (exp_q.size() > 0)
         check("rand_last_byte", 32'(rx_byte), 32'(exp_q[exp_q.size() - 1]));

      check("never_both", 32'(both_high), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
